// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with one-entry skid buffer; PIPE_STAGE_STATS_EN adds a stall counter.
// Latency 1 cycle (2+ via skid); up_stall is a flop output, FREEZE/FLUSH never reach it combinationally.
module pipe_stage_reg #(
    parameter int IR_W = 32,
    parameter int PC_W = 32,
    parameter int X_W  = 5
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [IR_W-1:0] in_IR,
    input  logic [PC_W-1:0] in_PCp4,
    input  logic [X_W-1:0]  X_in,
    input  logic            FREEZE,
    input  logic            FLUSH,
    output logic            up_stall,
    output logic            valid,
    output logic [IR_W-1:0] IR,
    output logic [PC_W-1:0] PCp4,
    output logic [X_W-1:0]  X
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [PC_W-1:0] pcp4;
        logic [X_W-1:0]  x;
    } item_t;

    typedef enum logic {
        SKID_EMPTY = 1'b0,
        SKID_FULL  = 1'b1
    } state_t;

    state_t state_q, state_d;
    item_t  main_q, main_d;
    item_t  skid_q, skid_d;
    logic   valid_q, valid_d;
    item_t  in_item;
    logic   accept;

    assign in_item = {in_IR, in_PCp4, X_in};
    assign accept  = in_valid && (state_q == SKID_EMPTY);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= SKID_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
        end
    end

    // FLUSH outranks FREEZE; a frozen stage only ever writes the skid.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        valid_d = valid_q;
        if (FLUSH) begin
            state_d = SKID_EMPTY;
            main_d  = '0;
            skid_d  = '0;
            valid_d = 1'b0;
        end else if (FREEZE) begin
            if (accept) begin
                skid_d  = in_item;
                state_d = SKID_FULL;
            end
        end else if (state_q == SKID_FULL) begin
            main_d  = skid_q;
            valid_d = 1'b1;
            state_d = SKID_EMPTY;
        end else if (accept) begin
            main_d  = in_item;
            valid_d = 1'b1;
        end else begin
            main_d  = '0;
            valid_d = 1'b0;
        end
    end

    always_comb begin
        up_stall = (state_q == SKID_FULL);
        valid    = valid_q;
        IR       = main_q.ir;
        PCp4     = main_q.pcp4;
        X        = main_q.x;
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (FREEZE && valid_q && !FLUSH && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed, table-driven bench for pipe_stage_reg.
module tb_pipe_stage_reg;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_IR = '0;
    logic [31:0] in_PCp4 = '0;
    logic [4:0]  X_in = '0;
    logic        FREEZE = 1'b0;
    logic        FLUSH = 1'b0;
    logic        up_stall;
    logic        valid;
    logic [31:0] IR;
    logic [31:0] PCp4;
    logic [4:0]  X;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    pipe_stage_reg dut (
        .CLK      (CLK),
        .reset    (reset),
        .in_valid (in_valid),
        .in_IR    (in_IR),
        .in_PCp4  (in_PCp4),
        .X_in     (X_in),
        .FREEZE   (FREEZE),
        .FLUSH    (FLUSH),
        .up_stall (up_stall),
        .valid    (valid),
        .IR       (IR),
        .PCp4     (PCp4),
        .X        (X)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    typedef struct {
        logic        rst;
        logic        vin;
        logic [31:0] ir;
        logic [31:0] pc;
        logic [4:0]  x;
        logic        frz;
        logic        fls;
        logic        e_vld;
        logic [31:0] e_ir;
        logic [31:0] e_pc;
        logic [4:0]  e_x;
        logic        e_stall;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic vin, input logic [31:0] ir,
                       input logic [31:0] pc, input logic [4:0] x, input logic frz,
                       input logic fls, input logic e_vld, input logic [31:0] e_ir,
                       input logic [31:0] e_pc, input logic [4:0] e_x, input logic e_stall);
        vec_t v;
        v.rst = rst; v.vin = vin; v.ir = ir; v.pc = pc; v.x = x; v.frz = frz; v.fls = fls;
        v.e_vld = e_vld; v.e_ir = e_ir; v.e_pc = e_pc; v.e_x = e_x; v.e_stall = e_stall;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs just after an edge, clock once, then sample 1 time unit after the edge.
    task automatic drive_tick(input logic rst, input logic vin, input logic [31:0] ir,
                              input logic [31:0] pc, input logic [4:0] x,
                              input logic frz, input logic fls);
        reset = rst; in_valid = vin; in_IR = ir; in_PCp4 = pc; X_in = x;
        FREEZE = frz; FLUSH = fls;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        //   rst vin ir            pc   x  frz fls | vld ir    pc  x  stall
        add(1, 1, 32'h2108000A, 4,  1, 0, 0,   0, 0,    0,  0, 0); // reset while offered
        add(0, 1, 1,            4,  0, 0, 0,   1, 1,    4,  0, 0); // streaming
        add(0, 1, 2,            8,  2, 0, 0,   1, 2,    8,  2, 0);
        add(0, 1, 3,            12, 3, 0, 0,   1, 3,    12, 3, 0);
        add(0, 1, 4,            16, 0, 0, 0,   1, 4,    16, 0, 0);
        add(0, 1, 32'hA,        20, 0, 0, 0,   1, 32'hA, 20, 0, 0); // A
        add(0, 1, 32'hB,        24, 5, 1, 0,   1, 32'hA, 20, 0, 1); // B into skid
        add(0, 1, 32'hC,        28, 0, 1, 0,   1, 32'hA, 20, 0, 1);
        add(0, 1, 32'hC,        28, 0, 1, 0,   1, 32'hA, 20, 0, 1);
        add(0, 1, 32'hC,        28, 0, 0, 0,   1, 32'hB, 24, 5, 0); // drain skid, C refused
        add(0, 1, 32'hC,        28, 0, 0, 0,   1, 32'hC, 28, 0, 0);
        add(0, 1, 32'hD,        32, 0, 1, 0,   1, 32'hC, 28, 0, 1); // D into skid
        add(0, 1, 32'hE,        36, 0, 1, 1,   0, 0,    0,  0, 0); // flush+freeze
        add(0, 1, 32'hE,        36, 0, 0, 0,   1, 32'hE, 36, 0, 0); // D lost, E accepted
        add(0, 0, 32'h55,       44, 2, 0, 0,   0, 0,    0,  0, 0); // bubbles
        add(0, 0, 32'h66,       48, 3, 0, 0,   0, 0,    0,  0, 0);
        add(0, 1, 32'hF,        40, 7, 0, 0,   1, 32'hF, 40, 7, 0);
        add(0, 0, 0,            0,  0, 1, 0,   1, 32'hF, 40, 7, 0); // freeze, nothing offered
        add(0, 0, 0,            0,  0, 0, 0,   0, 0,    0,  0, 0);
        add(0, 1, 32'h9,        52, 1, 1, 0,   0, 0,    0,  0, 1); // G into skid
        add(1, 1, 32'h10,       56, 2, 1, 0,   0, 0,    0,  0, 0); // reset mid-op
        add(0, 1, 32'h10,       56, 2, 0, 0,   1, 32'h10, 56, 2, 0);
        add(0, 1, 32'h11,       60, 3, 0, 1,   0, 0,    0,  0, 0); // flush discards input
        add(0, 0, 0,            0,  0, 0, 0,   0, 0,    0,  0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive_tick(vecs[i].rst, vecs[i].vin, vecs[i].ir, vecs[i].pc, vecs[i].x,
                       vecs[i].frz, vecs[i].fls);
            check($sformatf("vec%0d.valid", i), {31'd0, valid}, {31'd0, vecs[i].e_vld});
            check($sformatf("vec%0d.IR", i), IR, vecs[i].e_ir);
            check($sformatf("vec%0d.PCp4", i), PCp4, vecs[i].e_pc);
            check($sformatf("vec%0d.X", i), {27'd0, X}, {27'd0, vecs[i].e_x});
            check($sformatf("vec%0d.up_stall", i), {31'd0, up_stall}, {31'd0, vecs[i].e_stall});
        end

        // Freeze re-asserted the cycle right after a drain: new item goes straight to skid.
        drive_tick(0, 1, 32'h20, 64, 0, 1, 0);
        check("seq.first_freeze_hold", {31'd0, valid}, 32'd0);
        check("seq.first_freeze_stall", {31'd0, up_stall}, 32'd1);
        drive_tick(0, 1, 32'h21, 68, 0, 0, 0);
        check("seq.drain_ir", IR, 32'h20);
        check("seq.drain_stall", {31'd0, up_stall}, 32'd0);
        drive_tick(0, 1, 32'h21, 68, 0, 1, 0);
        check("seq.refreeze_hold", IR, 32'h20);
        check("seq.refreeze_stall", {31'd0, up_stall}, 32'd1);
        drive_tick(0, 1, 32'h22, 72, 0, 0, 0);
        check("seq.second_drain_ir", IR, 32'h21);
        drive_tick(0, 1, 32'h22, 72, 0, 0, 0);
        check("seq.next_ir", IR, 32'h22);
        drive_tick(0, 0, 0, 0, 0, 0, 0);
        check("seq.tail_bubble", {31'd0, valid}, 32'd0);

`ifdef PIPE_STAGE_STATS_EN
        drive_tick(1, 0, 0, 0, 0, 0, 0);
        check("stats.reset", stall_cnt, 32'd0);
        drive_tick(0, 1, 32'h30, 80, 0, 0, 0);
        for (int k = 0; k < 5; k++) drive_tick(0, 0, 0, 0, 0, 1, 0);
        check("stats.five", stall_cnt, 32'd5);
        check("stats.held_ir", IR, 32'h30);
        drive_tick(0, 0, 0, 0, 0, 1, 1);
        drive_tick(0, 0, 0, 0, 0, 1, 0);
        drive_tick(0, 0, 0, 0, 0, 1, 0);
        check("stats.no_count_invalid", stall_cnt, 32'd5);
        drive_tick(1, 0, 0, 0, 0, 1, 0);
        check("stats.cleared", stall_cnt, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
